ifu_resp: RTL

//  Instruction-fetch responder: the memory end of the fetch request/response interface driven by the PC/fetch side.

---
 rtl/ifu_resp_if.sv | 31 +++
 rtl/ifu_resp.sv | 103 ++++++++++
 2 files changed

// File: rtl/ifu_resp_if.sv
// Fetch request/response bus between the fetch unit (master) and the
// instruction responder (slave). It also carries the preload port.
//   req_valid/req_ready/req_addr     : fetch request handshake
//   resp_valid/resp_ready            : response handshake
//   resp_inst/resp_err               : returned word and access fault
//   ld_en/ld_idx/ld_data             : preload write into the word array
interface ifu_resp_if #(
  parameter int unsigned BITWIDTH   = 32,
  parameter int unsigned DEPTH_LOG2 = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic [BITWIDTH-1:0]   req_addr;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_inst;
  logic                  resp_err;
  logic                  ld_en;
  logic [DEPTH_LOG2-1:0] ld_idx;
  logic [31:0]           ld_data;

  modport master (
    output req_valid, req_addr, resp_ready, ld_en, ld_idx, ld_data,
    input  req_ready, resp_valid, resp_inst, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready, ld_en, ld_idx, ld_data,
    output req_ready, resp_valid, resp_inst, resp_err
  );
endinterface

// File: rtl/ifu_resp.sv
// Instruction-fetch responder. Accepts one word fetch at a time, waits
// LATENCY cycles, then presents the word from an internal preloadable array
// until the fetch side takes it.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : ifu_resp_if.slave (request, response and preload signals)
// Build option: define IFU_RESP_ERR_EN to flag misaligned or out-of-range
// fetches as faults; otherwise the offset wraps into the array and resp_err
// stays 0.
module ifu_resp #(
  parameter int unsigned         BITWIDTH   = 32,
  parameter logic [BITWIDTH-1:0] BASE_ADDR  = 'h8000_0000,
  parameter int unsigned         DEPTH_LOG2 = 12,
  parameter int unsigned         LATENCY    = 2
) (
  input logic      clk,
  input logic      rst,
  ifu_resp_if.slave bus
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [31:0]           r_mem [DEPTH];
  logic [1:0]            r_state;
  logic [BITWIDTH-1:0]   r_addr;
  logic [3:0]            r_cnt;
  logic [31:0]           r_inst;
  logic                  r_err;

  logic [BITWIDTH-1:0]   w_off;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_fault;

  // Byte offset from the array base; wraps for addresses below BASE_ADDR.
  assign w_off = r_addr - BASE_ADDR;
  assign w_idx = w_off[DEPTH_LOG2+1:2];

`ifdef IFU_RESP_ERR_EN
  localparam logic [BITWIDTH-1:0] SPAN = {{(BITWIDTH-1){1'b0}}, 1'b1} << (DEPTH_LOG2 + 2);
  assign w_fault = (r_addr[1:0] != 2'b00) || (w_off >= SPAN);
`else
  logic w_unused_bits;
  assign w_fault       = 1'b0;
  assign w_unused_bits = ^{w_off[1:0], w_off[BITWIDTH-1:DEPTH_LOG2+2]};
`endif

  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.resp_valid = (r_state == ST_RESP);
  assign bus.resp_inst  = r_inst;
  assign bus.resp_err   = r_err;

  // Storage is not reset; preload writes land in any state.
  always_ff @(posedge clk) begin
    if (bus.ld_en) begin
      r_mem[bus.ld_idx] <= bus.ld_data;
    end
  end

  // Every accept passes through WAIT with the counter loaded to LATENCY-1, so
  // RESP is entered exactly LATENCY edges after the accept edge. The array is
  // read on that entry edge, so a same-edge preload to that word is not seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_inst  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_addr  <= bus.req_addr;
            r_cnt   <= LAT_M1;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_RESP;
            r_inst  <= w_fault ? 32'h0 : r_mem[w_idx];
            r_err   <= w_fault;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
